// File: rtl/frame_timing_gen_if.sv
// -----------------------------------------------------------------------------
// frame_timing_gen_if
//   Bundles the sync/data inputs and the header/data/status outputs of
//   frame_timing_gen.
//   master : drives i_* (sync source / sample producer), observes o_*
//   slave  : the timing generator itself (reads i_*, drives o_*)
// Signals:
//   i_sync_25us     external 25 us frame sync, 1-cycle pulse
//   i_resync        soft resync pulse, forces UNLOCK
//   i_data/_vld     34-bit sample word and its valid
//   o_fram_hd_25us  frame header pulse
//   o_x8hd_25us     x8 header pulse
//   o_wfram_hd_25us write-frame header pulse
//   o_data_25us     gated, registered sample word
//   o_locked        high in LOCK or HOLD
//   o_sync_err      1-cycle pulse per misaligned sync
//   o_err_cnt       saturating misaligned-sync count
// -----------------------------------------------------------------------------
interface frame_timing_gen_if;
  logic        i_sync_25us;
  logic        i_resync;
  logic [33:0] i_data;
  logic        i_data_vld;
  logic        o_fram_hd_25us;
  logic        o_x8hd_25us;
  logic        o_wfram_hd_25us;
  logic [33:0] o_data_25us;
  logic        o_locked;
  logic        o_sync_err;
  logic [15:0] o_err_cnt;

  modport master (
    output i_sync_25us, i_resync, i_data, i_data_vld,
    input  o_fram_hd_25us, o_x8hd_25us, o_wfram_hd_25us, o_data_25us,
           o_locked, o_sync_err, o_err_cnt
  );

  modport slave (
    input  i_sync_25us, i_resync, i_data, i_data_vld,
    output o_fram_hd_25us, o_x8hd_25us, o_wfram_hd_25us, o_data_25us,
           o_locked, o_sync_err, o_err_cnt
  );
endinterface

// File: rtl/frame_timing_gen.sv
// -----------------------------------------------------------------------------
// frame_timing_gen
//   Locks a free-running frame counter to an external 25 us sync pulse and
//   generates the frame, x8 and write-frame headers for the delay stage.
//   The 34-bit sample stream is registered and gated with the same one-cycle
//   latency as the headers, so data, headers and lock status leave aligned.
// Ports:
//   clk        491.52 MHz clock
//   asy_rst_n  asynchronous active-low reset
//   bus        frame_timing_gen_if.slave (sync/data in, headers/data/status out)
// -----------------------------------------------------------------------------
module frame_timing_gen #(
  parameter int FRAME_LEN = 12288,  // cycles per frame, multiple of X8_PERIOD
  parameter int X8_PERIOD = 8,      // power of two
  parameter int WFRAM_OFS = 0,      // 0..FRAME_LEN-1
  parameter int MISS_MAX  = 3,      // 1..15
  parameter int HOLD_MAX  = 4       // 1..15
) (
  input  logic              clk,
  input  logic              asy_rst_n,
  frame_timing_gen_if.slave bus
);

  localparam int            CW       = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] CNT_WOFS = CW'(WFRAM_OFS);
  localparam logic [CW-1:0] X8_MASK  = CW'(X8_PERIOD - 1);
  localparam logic [3:0]    MISS_LIM = 4'(MISS_MAX);
  localparam logic [3:0]    HOLD_LIM = 4'(HOLD_MAX);

  typedef enum logic [1:0] {
    ST_UNLOCK = 2'd0,
    ST_LOCK   = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [3:0]    r_miss, w_miss_next;
  logic [3:0]    r_hold, w_hold_next;
  logic [15:0]   r_err_cnt, w_err_cnt_next;
  logic          r_fram_hd, w_fram_hd_next;
  logic          r_x8hd, w_x8hd_next;
  logic          r_wfram_hd, w_wfram_hd_next;
  logic          r_locked, w_locked_next;
  logic          r_sync_err, w_sync_err_next;
  logic [33:0]   r_data, w_data_next;

  // Event decode for the current cycle
  logic       w_in_lock;   // LOCK or HOLD
  logic       w_slot;      // expected sync slot
  logic       w_sync;      // sync not overridden by resync
  logic       w_aligned;
  logic       w_misalign;
  logic       w_missed;
  logic       w_realign;
  logic       w_drop;
  logic [3:0] w_hold_inc;

  assign w_in_lock  = (r_state != ST_UNLOCK);
  assign w_slot     = (r_cnt == CNT_LAST);
  assign w_sync     = bus.i_sync_25us & ~bus.i_resync;
  assign w_aligned  = w_in_lock & w_sync & w_slot;
  assign w_misalign = w_in_lock & w_sync & ~w_slot;
  assign w_missed   = w_in_lock & ~bus.i_sync_25us & w_slot;
  // Realign on the sync that makes the miss count reach its limit
  assign w_realign  = w_misalign & ((r_miss + 4'd1) == MISS_LIM);
  assign w_hold_inc = r_hold + 4'd1;
  // Covers LOCK too: leaving LOCK counts as the first missed slot
  assign w_drop     = w_missed & (w_hold_inc >= HOLD_LIM);

  // State register
  always_ff @(posedge clk or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      r_state <= ST_UNLOCK;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; resync overrides every other event
  always_comb begin
    w_state_next = r_state;
    if (bus.i_resync) begin
      w_state_next = ST_UNLOCK;
    end else begin
      case (r_state)
        ST_UNLOCK: begin
          if (bus.i_sync_25us) w_state_next = ST_LOCK;
        end
        ST_LOCK, ST_HOLD: begin
          if (w_aligned || w_realign) w_state_next = ST_LOCK;
          else if (w_missed)          w_state_next = w_drop ? ST_UNLOCK : ST_HOLD;
        end
        default: w_state_next = ST_UNLOCK;
      endcase
    end
  end

  // Counters and registered outputs
  always_comb begin
    w_cnt_next      = r_cnt + CW'(1);
    w_miss_next     = r_miss;
    w_hold_next     = r_hold;
    w_err_cnt_next  = r_err_cnt;
    w_sync_err_next = w_misalign;

    // UNLOCK pins the counter at 0 so a sync lands cnt=0 on the next cycle
    if (bus.i_resync || !w_in_lock || w_realign || w_slot) begin
      w_cnt_next = '0;
    end

    if (bus.i_resync || !w_in_lock || w_aligned || w_realign || w_drop) begin
      w_miss_next = '0;
      w_hold_next = '0;
    end else begin
      if (w_misalign) w_miss_next = r_miss + 4'd1;
      if (w_missed)   w_hold_next = w_hold_inc;
    end

    if (w_misalign && (r_err_cnt != 16'hFFFF)) begin
      w_err_cnt_next = r_err_cnt + 16'd1;
    end

    // Headers and data use the current state, so they leave together with
    // the o_locked value they are qualified by.
    w_locked_next   = w_in_lock;
    w_fram_hd_next  = w_in_lock & (r_cnt == '0);
    w_x8hd_next     = w_in_lock & ((r_cnt & X8_MASK) == '0);
    w_wfram_hd_next = w_in_lock & (r_cnt == CNT_WOFS);
    w_data_next     = (w_in_lock & bus.i_data_vld) ? bus.i_data : '0;
  end

  always_ff @(posedge clk or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      r_cnt      <= '0;
      r_miss     <= '0;
      r_hold     <= '0;
      r_err_cnt  <= '0;
      r_fram_hd  <= 1'b0;
      r_x8hd     <= 1'b0;
      r_wfram_hd <= 1'b0;
      r_locked   <= 1'b0;
      r_sync_err <= 1'b0;
      r_data     <= '0;
    end else begin
      r_cnt      <= w_cnt_next;
      r_miss     <= w_miss_next;
      r_hold     <= w_hold_next;
      r_err_cnt  <= w_err_cnt_next;
      r_fram_hd  <= w_fram_hd_next;
      r_x8hd     <= w_x8hd_next;
      r_wfram_hd <= w_wfram_hd_next;
      r_locked   <= w_locked_next;
      r_sync_err <= w_sync_err_next;
      r_data     <= w_data_next;
    end
  end

  assign bus.o_fram_hd_25us  = r_fram_hd;
  assign bus.o_x8hd_25us     = r_x8hd;
  assign bus.o_wfram_hd_25us = r_wfram_hd;
  assign bus.o_data_25us     = r_data;
  assign bus.o_locked        = r_locked;
  assign bus.o_sync_err      = r_sync_err;
  assign bus.o_err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_frame_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_frame_timing_gen
//   Bench for frame_timing_gen with a short frame (64 cycles) so that many
//   frames fit in a short run. Every cycle the full output vector is compared
//   with a reference model that tracks lock as an anchor time plus miss/hold
//   counts and derives the frame position arithmetically. Directed sequences
//   cover lock, misalignment, realignment, hold timeout, resync, data gating
//   and asynchronous reset; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_frame_timing_gen;
  localparam int FL   = 64;
  localparam int X8   = 8;
  localparam int WOFS = 5;
  localparam int MISS = 3;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic asy_rst_n = 1'b0;
  frame_timing_gen_if bus ();

  frame_timing_gen #(
    .FRAME_LEN(FL), .X8_PERIOD(X8), .WFRAM_OFS(WOFS),
    .MISS_MAX(MISS), .HOLD_MAX(HOLD)
  ) dut (
    .clk(clk),
    .asy_rst_n(asy_rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef logic [54:0] ovec_t;

  int errors = 0;
  int checks = 0;
  int t_cur  = 0;
  int last_fram_t = -1;
  int fram_cnt = 0;

  // Reference model state
  bit    m_locked;
  int    m_anchor;
  int    m_miss;
  int    m_hold;
  int    m_err;
  ovec_t m_exp;

  function automatic ovec_t dut_vec();
    return {bus.o_fram_hd_25us, bus.o_x8hd_25us, bus.o_wfram_hd_25us,
            bus.o_locked, bus.o_sync_err, bus.o_err_cnt, bus.o_data_25us};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, t_cur);
    end
  endtask

  // Frame position: the sync at m_anchor puts position 0 one cycle later
  function automatic int m_cnt(input int t);
    return m_locked ? ((t - m_anchor - 1) % FL) : 0;
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_anchor = 0;
    m_miss   = 0;
    m_hold   = 0;
    m_err    = 0;
    m_exp    = '0;
  endtask

  task automatic model_step(input int t, input bit s, input bit r,
                            input logic [33:0] d, input bit v);
    int c;
    bit fr, xh, wf, se;
    c  = m_cnt(t);
    fr = m_locked && (c == 0);
    xh = m_locked && ((c % X8) == 0);
    wf = m_locked && (c == WOFS);
    se = m_locked && s && !r && (c != FL - 1);
    if (se && m_err < 65535) m_err++;
    m_exp = {fr, xh, wf, m_locked, se, 16'(m_err), (m_locked && v) ? d : 34'h0};

    if (r) begin
      m_locked = 1'b0; m_miss = 0; m_hold = 0;
    end else if (!m_locked) begin
      if (s) begin
        m_locked = 1'b1; m_anchor = t; m_miss = 0; m_hold = 0;
      end
    end else if (s && c == FL - 1) begin
      m_miss = 0; m_hold = 0;
    end else if (s) begin
      m_miss++;
      if (m_miss == MISS) begin
        m_anchor = t; m_miss = 0; m_hold = 0;
      end
    end else if (c == FL - 1) begin
      m_hold++;
      if (m_hold >= HOLD) begin
        m_locked = 1'b0; m_miss = 0; m_hold = 0;
      end
    end
  endtask

  function automatic logic [33:0] rnd34();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[33:0];
  endfunction

  function automatic bit rbit();
    return 1'($urandom_range(1, 0));
  endfunction

  // One clock: drive after negedge, model at posedge, compare at next negedge
  task automatic cyc(input bit s, input bit r, input logic [33:0] d, input bit v);
    bus.i_sync_25us = s;
    bus.i_resync    = r;
    bus.i_data      = d;
    bus.i_data_vld  = v;
    @(posedge clk);
    model_step(t_cur, s, r, d, v);
    t_cur++;
    @(negedge clk);
    chk("outputs", 64'(dut_vec()), 64'(m_exp));
    if (bus.o_fram_hd_25us) begin
      last_fram_t = t_cur;
      fram_cnt++;
    end
  endtask

  task automatic idle_to(input int tt);
    while (t_cur < tt) cyc(1'b0, 1'b0, rnd34(), rbit());
  endtask

  task automatic sync_at(input int tt);
    idle_to(tt);
    cyc(1'b1, 1'b0, rnd34(), rbit());
  endtask

  typedef struct {
    bit          vld;
    logic [33:0] d;
    logic [33:0] exp;
  } data_vec_t;

  initial begin
    data_vec_t tbl[8];
    int ts, tr, t1, t2, fc;

    tbl[0] = '{1'b1, 34'h2_AAAA_5555, 34'h2_AAAA_5555};
    tbl[1] = '{1'b0, 34'h2_AAAA_5555, 34'h0};
    tbl[2] = '{1'b1, 34'h1_2345_6789, 34'h1_2345_6789};
    tbl[3] = '{1'b1, 34'h0,           34'h0};
    tbl[4] = '{1'b0, 34'h3_FFFF_FFFF, 34'h0};
    tbl[5] = '{1'b1, 34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF};
    tbl[6] = '{1'b0, 34'h1_5555_AAAA, 34'h0};
    tbl[7] = '{1'b1, 34'h2_AAAA_5555, 34'h2_AAAA_5555};

    model_reset();
    bus.i_sync_25us = 1'b0;
    bus.i_resync    = 1'b0;
    bus.i_data      = '0;
    bus.i_data_vld  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(dut_vec()), 64'(0));
    asy_rst_n = 1'b1;
    t_cur = 0;

    // Lock from reset: sync at 100, o_locked and first headers at 102
    ts = 100;
    sync_at(ts);
    chk("lock_not_yet", 64'(bus.o_locked), 64'(0));
    cyc(1'b0, 1'b0, rnd34(), rbit());
    chk("lock_locked", 64'(bus.o_locked), 64'(1));
    chk("lock_fram", 64'(bus.o_fram_hd_25us), 64'(1));
    chk("lock_x8", 64'(bus.o_x8hd_25us), 64'(1));
    sync_at(ts + FL);
    sync_at(ts + 2 * FL);
    chk("fram_period", 64'(last_fram_t), 64'(ts + FL + 2));
    chk("no_err_aligned", 64'(bus.o_err_cnt), 64'(0));

    // Single sync shifted +5: one error, no realignment
    sync_at(ts + 3 * FL + 5);
    chk("shift1_pulse", 64'(bus.o_sync_err), 64'(1));
    chk("shift1_cnt", 64'(bus.o_err_cnt), 64'(1));
    chk("shift1_locked", 64'(bus.o_locked), 64'(1));
    sync_at(ts + 4 * FL);
    chk("realigned_sync_ok", 64'(bus.o_sync_err), 64'(0));
    chk("shift1_no_realign", 64'(last_fram_t), 64'(ts + 3 * FL + 2));

    // Three shifted syncs: realign on the third
    sync_at(ts + 5 * FL + 5);
    sync_at(ts + 6 * FL + 5);
    chk("shift3_cnt2", 64'(bus.o_err_cnt), 64'(3));
    tr = ts + 7 * FL + 5;
    sync_at(tr);
    chk("shift3_cnt3", 64'(bus.o_err_cnt), 64'(4));
    cyc(1'b0, 1'b0, rnd34(), rbit());
    chk("realign_fram", 64'(bus.o_fram_hd_25us), 64'(1));
    chk("realign_time", 64'(last_fram_t), 64'(tr + 2));

    // Syncs stop: HOLD for the missed slots, lock dropped at the 4th
    idle_to(tr + 4 * FL + 1);
    chk("hold_locked", 64'(bus.o_locked), 64'(1));
    chk("hold_last_fram", 64'(last_fram_t), 64'(tr + 3 * FL + 2));
    cyc(1'b0, 1'b0, rnd34(), rbit());
    chk("hold_dropped", 64'(bus.o_locked), 64'(0));
    chk("hold_no_fram", 64'(bus.o_fram_hd_25us), 64'(0));
    fc = fram_cnt;
    idle_to(tr + 5 * FL + 10);
    chk("unlock_quiet", 64'(fram_cnt), 64'(fc));

    // Resync coincident with an aligned sync
    t1 = t_cur + 20;
    sync_at(t1);
    idle_to(t1 + FL);
    cyc(1'b1, 1'b1, rnd34(), rbit());
    chk("resync_no_err", 64'(bus.o_sync_err), 64'(0));
    chk("resync_locked_lag", 64'(bus.o_locked), 64'(1));
    cyc(1'b0, 1'b0, rnd34(), rbit());
    chk("resync_unlocked", 64'(bus.o_locked), 64'(0));
    chk("resync_err_kept", 64'(bus.o_err_cnt), 64'(4));
    idle_to(t1 + 2 * FL + 10);
    chk("resync_quiet", 64'(last_fram_t), 64'(t1 + 2));

    // Data gating table while locked
    t2 = t_cur + 3;
    sync_at(t2);
    cyc(1'b0, 1'b0, rnd34(), 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, tbl[i].d, tbl[i].vld);
      chk("data_row", 64'(bus.o_data_25us), 64'(tbl[i].exp));
    end

    // Asynchronous reset away from any clock edge
    #2 asy_rst_n = 1'b0;
    #1 chk("async_reset", 64'(dut_vec()), 64'(0));
    model_reset();
    @(negedge clk);
    t_cur++;
    asy_rst_n = 1'b1;
    repeat (5) cyc(1'b0, 1'b0, rnd34(), rbit());

    // Randomized phase: mostly aligned syncs, some dropped, stray and resync
    for (int i = 0; i < 4000; i++) begin
      bit s, r;
      s = ((m_cnt(t_cur) == FL - 1) && ($urandom_range(7, 0) != 0)) ||
          ($urandom_range(150, 0) == 0);
      r = ($urandom_range(1500, 0) == 0);
      cyc(s, r, rnd34(), rbit());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
